// File: rtl/gpio_config_shifter.sv
// gpio_config_shifter: loads per-pad GPIO configuration words into the pad-ring
// serial configuration chain. Pads are sent farthest-first (NUM_PADS-1 down to
// 0), each word MSB-first. After the last bit a load strobe makes every control
// block latch its word.
//
// Ports:
//   wb_clk_i      system clock, rising edge
//   wb_rstn_i     asynchronous active-low reset
//   start         request a full chain reload (sampled only while idle)
//   busy          transfer in progress (FETCH..LOAD)
//   done          one-cycle completion pulse
//   cfg_addr      pad index presented to the config register file
//   cfg_data      config word for cfg_addr (combinational read)
//   serial_clock  chain shift clock
//   serial_data   chain data, changes only while serial_clock is low
//   serial_load   chain latch strobe
// All outputs are registered.
module gpio_config_shifter #(
  parameter int unsigned NUM_PADS    = 19,
  parameter int unsigned WORD_W      = 13,
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic                                                  wb_clk_i,
  input  logic                                                  wb_rstn_i,
  input  logic                                                  start,
  output logic                                                  busy,
  output logic                                                  done,
  output logic [((NUM_PADS > 1) ? $clog2(NUM_PADS) : 1)-1:0]    cfg_addr,
  input  logic [WORD_W-1:0]                                     cfg_data,
  output logic                                                  serial_clock,
  output logic                                                  serial_data,
  output logic                                                  serial_load
);

  localparam int unsigned AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     pad_q, pad_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              sdat_q, sdat_d;
  logic              sload_q, sload_d;
  logic              ph_end_c;

  // Last cycle of a HALF_PERIOD-long phase (LOW, HIGH, LOAD).
  assign ph_end_c = (ph_q == LAST_PH);

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= S_IDLE;
      pad_q   <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      sload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sload_q <= sload_d;
    end
  end

  // Next state; output _d values are those of the state being entered, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    pad_d   = pad_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    sdat_d  = sdat_q;
    sload_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        sclk_d = 1'b0;
        sdat_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          pad_d   = LAST_PAD;
          busy_d  = 1'b1;
        end
      end

      S_FETCH: begin
        shreg_d = cfg_data;
        bit_d   = LAST_BIT;
        ph_d    = '0;
        sclk_d  = 1'b0;
        sdat_d  = cfg_data[WORD_W-1];
        state_d = S_LOW;
      end

      S_LOW: begin
        if (ph_end_c) begin
          ph_d    = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      S_HIGH: begin
        if (ph_end_c) begin
          ph_d    = '0;
          sclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          if (bit_q != '0) begin
            bit_d   = bit_q - BW'(1);
            sdat_d  = shreg_d[WORD_W-1];
            state_d = S_LOW;
          end else if (pad_q != '0) begin
            pad_d   = pad_q - AW'(1);
            sdat_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            sdat_d  = 1'b0;
            sload_d = 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      S_LOAD: begin
        if (ph_end_c) begin
          ph_d    = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ph_d    = ph_q + PW'(1);
          sload_d = 1'b1;
        end
      end

      // A start seen here is dropped; IDLE samples it next cycle if still high.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_addr     = pad_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdat_q;
  assign serial_load  = sload_q;

endmodule

// File: tb/tb_gpio_config_shifter.sv
// Scoreboard bench for gpio_config_shifter. Three instances share clock/reset:
//   0: NUM_PADS=2,  HALF_PERIOD=1
//   1: NUM_PADS=2,  HALF_PERIOD=3
//   2: defaults (NUM_PADS=19, HALF_PERIOD=2)
// Stimulus pushes expected serial bits and done cycles into per-instance
// queues; a monitor pops them on every serial_clock rise / done pulse.
`timescale 1ns/1ps
module tb_gpio_config_shifter;

  localparam int W  = 13;
  localparam int NI = 3;

  int np_arr[NI] = '{2, 2, 19};
  int hp_arr[NI] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] start_v;
  logic [NI-1:0] busy_v, done_v, sclk_v, sdat_v, sload_v;
  logic [0:0]    addr_a, addr_b;
  logic [4:0]    addr_c;
  logic [12:0]   cfg_a [2];
  logic [12:0]   cfg_b [2];
  logic [12:0]   cfg_c [32];
  logic [12:0]   data_a, data_b, data_c;

  assign data_a = cfg_a[addr_a];
  assign data_b = cfg_b[addr_b];
  assign data_c = cfg_c[addr_c];

  gpio_config_shifter #(.NUM_PADS(2), .WORD_W(13), .HALF_PERIOD(1)) u_a (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .cfg_addr(addr_a), .cfg_data(data_a),
    .serial_clock(sclk_v[0]), .serial_data(sdat_v[0]), .serial_load(sload_v[0]));

  gpio_config_shifter #(.NUM_PADS(2), .WORD_W(13), .HALF_PERIOD(3)) u_b (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .cfg_addr(addr_b), .cfg_data(data_b),
    .serial_clock(sclk_v[1]), .serial_data(sdat_v[1]), .serial_load(sload_v[1]));

  gpio_config_shifter u_c (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .cfg_addr(addr_c), .cfg_data(data_c),
    .serial_clock(sclk_v[2]), .serial_data(sdat_v[2]), .serial_load(sload_v[2]));

  // Hand-computed streams: cfg[1]=13'h1803 then cfg[0]=13'h0402, and 13'h0402.
  logic [25:0] stream_ab = 26'b1100000000011_0010000000010;
  logic [12:0] word_c    = 13'b0010000000010;

  bit exp_bits_q [NI][$];
  int exp_done_q [NI][$];

  task automatic check(input int inst, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", inst, name, act, exp, cyc);
    end
  endtask

  function automatic int done_lat(input int i);
    return np_arr[i] * (1 + 2 * hp_arr[i] * W) + hp_arr[i] + 1;
  endfunction

  // c0 is the cyc value of the cycle in which start is accepted.
  task automatic expect_transfer(input int i, input int c0);
    if (i == 2) begin
      for (int p = 0; p < 19; p++)
        for (int b = W - 1; b >= 0; b--) exp_bits_q[i].push_back(word_c[b]);
    end else begin
      for (int b = 25; b >= 0; b--) exp_bits_q[i].push_back(stream_ab[b]);
    end
    exp_done_q[i].push_back(c0 + done_lat(i));
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    expect_transfer(i, cyc);
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit prev_sclk[NI], prev_sdat[NI];
  int stable_cnt[NI], since_rise[NI], high_len[NI], low_len[NI], rise_idx[NI];
  int load_cnt[NI], last_load[NI], busy_cnt[NI], done_seen[NI];
  bit m_clk, m_dat, m_rise, m_fall, m_chg, exp_b;

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          prev_sclk[i] = 1'b0; prev_sdat[i] = 1'b0;
          stable_cnt[i] = 0; since_rise[i] = 1000; high_len[i] = 0; low_len[i] = 0;
          rise_idx[i] = 0; load_cnt[i] = 0; busy_cnt[i] = 0;
        end else begin
          m_clk  = sclk_v[i];
          m_dat  = sdat_v[i];
          m_rise = m_clk && !prev_sclk[i];
          m_fall = !m_clk && prev_sclk[i];
          m_chg  = (m_dat != prev_sdat[i]);
          stable_cnt[i] = m_chg ? 0 : stable_cnt[i] + 1;
          since_rise[i] = m_rise ? 0 : since_rise[i] + 1;

          if (m_chg) begin
            check(i, "data_change_clk", int'(m_clk), 0);
            check(i, "data_hold", int'(since_rise[i] >= hp_arr[i]), 1);
          end

          if (m_rise) begin
            if (exp_bits_q[i].size() == 0)
              check(i, "unexpected_rise_qsize", exp_bits_q[i].size(), 1);
            else begin
              exp_b = exp_bits_q[i].pop_front();
              check(i, "serial_bit", int'(m_dat), int'(exp_b));
            end
            check(i, "data_setup", int'(stable_cnt[i] >= hp_arr[i]), 1);
            if (rise_idx[i] > 0)
              check(i, "low_phase", low_len[i],
                    (rise_idx[i] % W == 0) ? hp_arr[i] + 1 : hp_arr[i]);
            rise_idx[i]++;
            low_len[i] = 0;
          end else if (!m_clk) begin
            low_len[i]++;
          end

          if (m_fall) begin
            check(i, "high_phase", high_len[i], hp_arr[i]);
            high_len[i] = 0;
          end else if (m_clk) begin
            high_len[i]++;
          end

          if (sload_v[i]) begin
            check(i, "load_vs_clk", int'(m_clk), 0);
            load_cnt[i]++;
            last_load[i] = cyc;
          end
          if (busy_v[i]) busy_cnt[i]++;

          if (done_v[i]) begin
            if (exp_done_q[i].size() == 0)
              check(i, "unexpected_done_qsize", exp_done_q[i].size(), 1);
            else
              check(i, "done_cycle", cyc, exp_done_q[i].pop_front());
            check(i, "busy_at_done", int'(busy_v[i]), 0);
            check(i, "load_len", load_cnt[i], hp_arr[i]);
            check(i, "load_end", last_load[i], cyc - 1);
            check(i, "busy_len", busy_cnt[i], np_arr[i] * (1 + 2 * hp_arr[i] * W) + hp_arr[i]);
            load_cnt[i] = 0;
            busy_cnt[i] = 0;
            rise_idx[i] = 0;
            done_seen[i]++;
          end

          prev_sclk[i] = m_clk;
          prev_sdat[i] = m_dat;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int i, input int target, input int budget);
    int n = 0;
    while (done_seen[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(i, "done_timeout", int'(done_seen[i] >= target), 1);
  endtask

  int any_act, base;

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    cfg_a[1] = 13'h1803; cfg_a[0] = 13'h0402;
    cfg_b[1] = 13'h1803; cfg_b[0] = 13'h0402;
    for (int k = 0; k < 32; k++) cfg_c[k] = 13'h0402;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start: everything stays quiet.
    any_act = 0;
    repeat (100) begin
      @(negedge clk);
      any_act |= int'(|{busy_v, done_v, sclk_v, sdat_v, sload_v, addr_a, addr_b, addr_c});
    end
    check(0, "idle_quiet", any_act, 0);

    // Basic transfer, HALF_PERIOD=1.
    base = done_seen[0];
    pulse_start(0);
    wait_done(0, base + 1, 200);

    // Same stream, HALF_PERIOD=3.
    base = done_seen[1];
    pulse_start(1);
    wait_done(1, base + 1, 400);

    // Start re-pulsed mid pad 1 while cfg[1] changes: no restart, no re-sample.
    base = done_seen[0];
    pulse_start(0);
    repeat (11) @(negedge clk);
    start_v[0] = 1'b1;
    cfg_a[1]   = 13'h1FFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, base + 1, 200);
    cfg_a[1] = 13'h1803;

    // Reset during pad 0: outputs clear asynchronously, then a clean rerun.
    pulse_start(0);
    repeat (35) @(negedge clk);
    check(0, "busy_before_reset", int'(busy_v[0]), 1);
    rst_n = 1'b0;
    exp_bits_q[0].delete();
    exp_done_q[0].delete();
    #1;
    check(0, "rst_busy", int'(busy_v[0]), 0);
    check(0, "rst_sclk", int'(sclk_v[0]), 0);
    check(0, "rst_sdat", int'(sdat_v[0]), 0);
    check(0, "rst_sload", int'(sload_v[0]), 0);
    check(0, "rst_done", int'(done_v[0]), 0);
    check(0, "rst_addr", int'(addr_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_act = 0;
    repeat (5) begin
      @(negedge clk);
      any_act |= int'(busy_v[0] | sclk_v[0] | done_v[0]);
    end
    check(0, "idle_after_reset", any_act, 0);
    base = done_seen[0];
    pulse_start(0);
    wait_done(0, base + 1, 200);

    // Default instance, start held high: two back-to-back transfers.
    base = done_seen[2];
    @(negedge clk);
    start_v[2] = 1'b1;
    expect_transfer(2, cyc);
    expect_transfer(2, cyc + done_lat(2) + 1);
    wait_done(2, base + 2, 2 * done_lat(2) + 50);
    start_v[2] = 1'b0;

    repeat (30) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check(i, "bits_left", exp_bits_q[i].size(), 0);
      check(i, "dones_left", exp_done_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_config_shifter.md
Name: gpio_config_shifter

Overview:
Sequencer that loads the per-pad GPIO configuration words into the serial configuration chain formed by the GPIO control blocks. On a start request it fetches each pad's 13-bit word from the housekeeping configuration register file, one pad at a time. It shifts each word MSB-first onto serial_data with a generated serial_clock, then pulses serial_load so every control block latches its word. The block sits in housekeeping, between the register file (which initially holds the mask-programmed defaults) and the pad-ring serial chain.

Parameters:
NUM_PADS, 19, number of control blocks in the chain (>=1)
WORD_W, 13, configuration word width per pad
HALF_PERIOD, 2, wb_clk_i cycles per serial_clock half period (>=1)

Ports:
wb_clk_i  input  1  system clock; all state updates on rising edge
wb_rstn_i  input  1  asynchronous active-low reset
start  input  1  single-cycle request to (re)load the whole chain; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse when the load completes
cfg_addr  output  $clog2(NUM_PADS) (min 1)  pad index being fetched; registered
cfg_data  input  WORD_W  config word for cfg_addr; combinational read, valid in the same cycle
serial_clock  output  1  chain shift clock; registered
serial_data  output  WORD_W-independent 1  chain data; registered
serial_load  output  1  chain latch strobe; registered

Behaviour:
- Interface fact: one clock (wb_clk_i); reset wb_rstn_i is asynchronous and active-low.
- Reset values: busy=0, done=0, cfg_addr=0, serial_clock=0, serial_data=0, serial_load=0, FSM=IDLE, counters=0. Reset asserted mid-transfer aborts immediately with the same values; there is no resume.
- All outputs are registered; there is no combinational path from an input to an output.
- States: IDLE, FETCH, LOW, HIGH, LOAD, DONE.
- IDLE: start=1 -> FETCH; pad_idx=NUM_PADS-1; cfg_addr=NUM_PADS-1; busy=1.
- FETCH (1 cycle): shreg<=cfg_data; bit_cnt<=WORD_W-1; serial_clock=0; serial_data=0. Next state is LOW.
- LOW (HALF_PERIOD cycles): serial_data=shreg[WORD_W-1]; serial_clock=0. Next state is HIGH.
- HIGH (HALF_PERIOD cycles): serial_clock=1; serial_data held stable through the whole phase.
- HIGH exit: shreg shifts left by 1.
  - If bit_cnt!=0: bit_cnt-1, go to LOW.
  - Else if pad_idx!=0: pad_idx-1, cfg_addr follows, go to FETCH.
  - Else: go to LOAD.
- LOAD (HALF_PERIOD cycles): serial_load=1; serial_clock=0; serial_data=0. Next state is DONE.
- DONE (1 cycle): done=1; busy=0. Next state is IDLE.
- Shift order: the farthest pad (NUM_PADS-1) goes first, each word MSB first. After NUM_PADS*WORD_W rising edges, pad k's control block holds cfg_data[k].
- serial_data changes only while serial_clock=0, giving a full HALF_PERIOD of setup and of hold around each rising edge.
- serial_load never overlaps serial_clock=1.
- Latency: start accepted at cycle 0. Total busy length is NUM_PADS*(1+2*HALF_PERIOD*WORD_W) cycles, then HALF_PERIOD cycles of LOAD, then done in the following cycle.
- start while busy (any state other than IDLE) is ignored; it is neither queued nor restarts the transfer.
- start in the DONE cycle is ignored.
- start held high continuously: a new transfer begins on the first IDLE cycle after DONE.
- cfg_data is sampled only in FETCH; changes at other times have no effect on the word in flight.
- NUM_PADS=1: FETCH occurs once, with cfg_addr=0.

Test Plan:
- Reset then idle, no start -> all outputs 0 for 100 cycles; serial_clock shows no edges.
- NUM_PADS=2, HALF_PERIOD=1, cfg[1]=13'h1803, cfg[0]=13'h0402, pulse start -> expected response:
  - serial_data sampled on serial_clock rise yields 1100000000011 then 0010000000010.
  - Exactly 26 rising edges.
  - serial_load high 1 cycle at cycle 55.
  - done at cycle 56.
  - busy high for cycles 1..55.
- Same setup with HALF_PERIOD=3 -> identical bitstream. serial_clock high/low phases are each exactly 3 cycles. serial_data is stable for 3 cycles before and after every rising edge. serial_load is high 3 cycles.
- start pulsed again at bit 5 of pad 1 -> no restart. The bitstream and done timing are unchanged from the undisturbed run.
- wb_rstn_i asserted during pad 0 shift -> outputs 0 asynchronously, and FSM is in IDLE after release. A new start then produces the full correct 26-bit stream.
- Default params, cfg[k]=13'h0402 for all k, start held high -> two back-to-back transfers of 247 bits each. done pulses twice, separated by exactly one IDLE cycle.
